// File: rtl/sprite_pkg.sv
// Shared types and colour constants for the sprite pixel path.
package sprite_pkg;
   typedef logic signed [10:0] coord_t;
   typedef logic [11:0]        rgb_t;

   localparam rgb_t RGB_BLACK = 12'h000;
   localparam rgb_t RGB_RED   = 12'hF00;
   localparam rgb_t RGB_GREEN = 12'h0F0;
   localparam rgb_t RGB_WHITE = 12'hFFF;
endpackage

// File: rtl/sprite_bounds.sv
// Sprite-relative coordinates and inside test.
// Coordinates are widened to 12 bits so the subtraction never wraps.
module sprite_bounds
   import sprite_pkg::*;
#(
   parameter int SIZE = 256
) (
   input  coord_t             i_row,
   input  coord_t             i_column,
   input  coord_t             i_row_offset,
   input  coord_t             i_column_offset,
   output logic signed [11:0] o_rel_r,
   output logic signed [11:0] o_rel_c,
   output logic               o_inside
);
   localparam logic [10:0] SIZE_W = 11'(SIZE);

   logic w_r_in;
   logic w_c_in;

   assign o_rel_r = {i_row[10], i_row} - {i_row_offset[10], i_row_offset};
   assign o_rel_c = {i_column[10], i_column} - {i_column_offset[10], i_column_offset};

   // Non-negative and below SIZE; bit 11 is the sign of the widened difference.
   assign w_r_in = !o_rel_r[11] && (o_rel_r[10:0] < SIZE_W);
   assign w_c_in = !o_rel_c[11] && (o_rel_c[10:0] < SIZE_W);

   assign o_inside = w_r_in && w_c_in;
endmodule

// File: rtl/sprite_square_rom.sv
// Procedural checkerboard sprite: pixel (row, column) -> registered RGB444.
// Optional white one-pixel frame when SPRITE_BORDER_EN is defined.
module sprite_square_rom
   import sprite_pkg::*;
#(
   parameter int   SIZE      = 256,
   parameter int   CELL_LOG2 = 0,
   parameter rgb_t COLOR_A   = RGB_RED,
   parameter rgb_t COLOR_B   = RGB_GREEN,
   parameter rgb_t COLOR_BG  = RGB_BLACK
) (
   input  logic   clk,
   input  logic   rst_n,
   input  coord_t row,
   input  coord_t column,
   input  coord_t row_offset,
   input  coord_t column_offset,
   output rgb_t   q
);
   logic signed [11:0] w_rel_r;
   logic signed [11:0] w_rel_c;
   logic               w_inside;
   logic               w_par;
   rgb_t               w_q_next;
   rgb_t               r_q;

   sprite_bounds #(
      .SIZE (SIZE)
   ) u_bounds (
      .i_row           (row),
      .i_column        (column),
      .i_row_offset    (row_offset),
      .i_column_offset (column_offset),
      .o_rel_r         (w_rel_r),
      .o_rel_c         (w_rel_c),
      .o_inside        (w_inside)
   );

   // Only meaningful when inside, where both rel values are non-negative.
   assign w_par = |(((w_rel_r ^ w_rel_c) >> CELL_LOG2) & 12'sd1);

`ifdef SPRITE_BORDER_EN
   localparam logic signed [11:0] EDGE = 12'(SIZE - 1);
   logic w_border;
   assign w_border = (w_rel_r == 12'sd0) || (w_rel_r == EDGE) ||
                     (w_rel_c == 12'sd0) || (w_rel_c == EDGE);
   assign w_q_next = !w_inside ? COLOR_BG :
                     w_border  ? RGB_WHITE :
                     (w_par ? COLOR_B : COLOR_A);
`else
   assign w_q_next = !w_inside ? COLOR_BG : (w_par ? COLOR_B : COLOR_A);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= RGB_BLACK;
      else        r_q <= w_q_next;
   end

   assign q = r_q;
endmodule

// File: tb/tb_sprite_square_rom.sv
// Directed bench for sprite_square_rom: reset, checker pattern, edges, pipeline.
// Border expectations follow SPRITE_BORDER_EN when the build defines it.
module tb_sprite_square_rom;
   import sprite_pkg::*;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   coord_t row = '0, column = '0, row_offset = '0, column_offset = '0;
   rgb_t   q;

   int total = 0;
   int bad   = 0;

   sprite_square_rom #(
      .SIZE      (256),
      .CELL_LOG2 (0),
      .COLOR_A   (12'hF00),
      .COLOR_B   (12'h0F0),
      .COLOR_BG  (12'h000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .row           (row),
      .column        (column),
      .row_offset    (row_offset),
      .column_offset (column_offset),
      .q             (q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input rgb_t got, input rgb_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%03h exp=%03h", tag, got, exp);
      end
   endtask

   // Drive a pixel just after an edge, check q one edge later.
   task automatic px(input string tag, input int r, input int c, input rgb_t exp);
      row    = 11'(r);
      column = 11'(c);
      @(posedge clk); #1;
      chk(tag, q, exp);
   endtask

   typedef struct { int r; int c; rgb_t e; } vec_t;
   vec_t pv[8];

`ifdef SPRITE_BORDER_EN
   localparam rgb_t CORNER = 12'hFFF;
`else
   localparam rgb_t CORNER = 12'hF00;
`endif

   initial begin
      // reset held with an in-sprite pixel on the inputs
      row_offset = -11'sd50; column_offset = 11'sd50;
      row = 11'sd100; column = 11'sd100;
      #1 chk("rst_async", q, 12'h000);
      repeat (2) @(posedge clk);
      #1 chk("rst_hold", q, 12'h000);
      #3 rst_n = 1'b1;
      #1 chk("rst_release", q, 12'h000);
      @(posedge clk); #1;
      chk("rst_first_edge", q, 12'hF00);

      px("outside_0_0",     0,   0,   12'h000);
      px("outside_700_500", 700, 500, 12'h000);
      px("ck_100_100",      100, 100, 12'hF00);
      px("ck_100_101",      100, 101, 12'h0F0);
      px("ck_101_100",      101, 100, 12'h0F0);
      px("ck_101_101",      101, 101, 12'hF00);
      px("ck_50_150",       50,  150, 12'hF00);
      px("ck_50_151",       50,  151, 12'h0F0);
      px("ck_51_150",       51,  150, 12'h0F0);
      px("ck_51_151",       51,  151, 12'hF00);

      // edges at origin (0,0); offsets change together with the pixel
      row_offset = 11'sd0; column_offset = 11'sd0;
      px("edge_0_0",     0,   0,   CORNER);
      px("edge_255_255", 255, 255, CORNER);
      px("edge_256_0",   256, 0,   12'h000);
      px("edge_m1_5",    -1,  5,   12'h000);
      px("edge_0_256",   0,   256, 12'h000);
      px("edge_5_m1",    5,   -1,  12'h000);

      // new pixel every cycle; each q must reflect exactly the previous sample
      row_offset = -11'sd50; column_offset = 11'sd50;
      pv[0] = '{100, 100, 12'hF00};
      pv[1] = '{100, 101, 12'h0F0};
      pv[2] = '{0,   0,   12'h000};
      pv[3] = '{101, 101, 12'hF00};
      pv[4] = '{101, 102, 12'h0F0};
      pv[5] = '{50,  150, 12'hF00};
      pv[6] = '{700, 500, 12'h000};
      pv[7] = '{51,  150, 12'h0F0};
      for (int i = 0; i < 8; i++)
         px($sformatf("pipe_%0d", i), pv[i].r, pv[i].c, pv[i].e);

      // reset mid-stream, away from the clock edge
      px("pre_midrst", 100, 100, 12'hF00);
      #2 rst_n = 1'b0;
      #1 chk("midrst_async", q, 12'h000);
      @(posedge clk); #1;
      chk("midrst_hold", q, 12'h000);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_resume", q, 12'hF00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
